// File: rtl/vga_sync_gen.sv
// 640x480@60 Hz VGA raster timing generator with per-axis region FSMs.
// Every output is a registered decode of the current counter position, so it is glitch-free.
module vga_sync_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FRONT  = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BACK   = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FRONT  = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BACK   = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk_25,
    input  logic       reset,
    input  logic       enable,
    output logic       h_sync,
    output logic       v_sync,
    output logic       bright,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_too_large
            $error("vga_sync_gen: H_TOTAL or V_TOTAL exceeds the 10-bit counter range");
        end
    endgenerate

    localparam logic [1:0] ACTIVE = 2'd0;
    localparam logic [1:0] FRONT  = 2'd1;
    localparam logic [1:0] SYNC   = 2'd2;
    localparam logic [1:0] BACK   = 2'd3;

    localparam logic [9:0] H_LAST        = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FRONT_START = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_START  = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] H_BACK_START  = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_LAST        = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FRONT_START = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_START  = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] V_BACK_START  = 10'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [9:0] h_count;
    logic [9:0] v_count;
    logic [1:0] h_state;
    logic [1:0] v_state;

    logic       h_wrap;
    logic       v_wrap;
    logic       visible;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic [1:0] h_state_next;
    logic [1:0] v_state_next;

    assign h_wrap  = (h_count == H_LAST);
    assign v_wrap  = (v_count == V_LAST);
    assign visible = (h_state == ACTIVE) && (v_state == ACTIVE);

    // The state registers track the region the counters are entering, so they
    // always describe the current count; the vertical axis only moves on a line wrap.
    always_comb begin
        h_next       = h_wrap ? 10'd0 : h_count + 10'd1;
        v_next       = v_count;
        h_state_next = h_state;
        v_state_next = v_state;

        case (h_state)
            ACTIVE:  if (h_next == H_FRONT_START) h_state_next = FRONT;
            FRONT:   if (h_next == H_SYNC_START)  h_state_next = SYNC;
            SYNC:    if (h_next == H_BACK_START)  h_state_next = BACK;
            default: if (h_wrap)                  h_state_next = ACTIVE;
        endcase

        if (h_wrap) begin
            v_next = v_wrap ? 10'd0 : v_count + 10'd1;
            case (v_state)
                ACTIVE:  if (v_next == V_FRONT_START) v_state_next = FRONT;
                FRONT:   if (v_next == V_SYNC_START)  v_state_next = SYNC;
                SYNC:    if (v_next == V_BACK_START)  v_state_next = BACK;
                default: if (v_wrap)                  v_state_next = ACTIVE;
            endcase
        end
    end

    // While disabled everything holds, except the pulses which drop so they never repeat.
    always_ff @(posedge clk_25) begin
        if (reset) begin
            h_count     <= 10'd0;
            v_count     <= 10'd0;
            h_state     <= ACTIVE;
            v_state     <= ACTIVE;
            h_sync      <= ~SYNC_POL;
            v_sync      <= ~SYNC_POL;
            bright      <= 1'b0;
            pixel_x     <= 10'd0;
            pixel_y     <= 10'd0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (enable) begin
            h_count     <= h_next;
            v_count     <= v_next;
            h_state     <= h_state_next;
            v_state     <= v_state_next;
            h_sync      <= (h_state == SYNC) ? SYNC_POL : ~SYNC_POL;
            v_sync      <= (v_state == SYNC) ? SYNC_POL : ~SYNC_POL;
            bright      <= visible;
            pixel_x     <= visible ? h_count : 10'd0;
            pixel_y     <= visible ? v_count : 10'd0;
            line_start  <= visible && (h_count == 10'd0);
            frame_start <= visible && (h_count == 10'd0) && (v_count == 10'd0);
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: a full-size instance checks line timing, freeze and reset; a
// shrunken instance (16x11 total) makes whole-frame checks affordable.
module tb_vga_sync_gen;

    logic       clk_25 = 1'b0;
    logic       reset;
    logic       enable;

    logic       d_h_sync, d_v_sync, d_bright, d_line_start, d_frame_start;
    logic [9:0] d_x, d_y;
    logic       s_h_sync, s_v_sync, s_bright, s_line_start, s_frame_start;
    logic [9:0] s_x, s_y;

    int checks_total  = 0;
    int checks_passed = 0;
    int checks_failed = 0;

    int d_bright_ones, d_first_dark, d_hs_low, d_hs_first, d_ls_count, d_fs_count, d_vs_low;
    int d_pix_bad, d_freeze_bad;
    int s_ls_count, s_fs_count, s_vs_low, s_vs_first, s_hs_low_line0;
    int s_run, s_runs, s_glitch, s_ones, s_pix_bad;

    vga_sync_gen dut_full (
        .clk_25(clk_25), .reset(reset), .enable(enable),
        .h_sync(d_h_sync), .v_sync(d_v_sync), .bright(d_bright),
        .pixel_x(d_x), .pixel_y(d_y),
        .line_start(d_line_start), .frame_start(d_frame_start)
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .SYNC_POL(1'b0)
    ) dut_small (
        .clk_25(clk_25), .reset(reset), .enable(enable),
        .h_sync(s_h_sync), .v_sync(s_v_sync), .bright(s_bright),
        .pixel_x(s_x), .pixel_y(s_y),
        .line_start(s_line_start), .frame_start(s_frame_start)
    );

    always #20 clk_25 = ~clk_25;

    task automatic tick();
        @(posedge clk_25);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else begin
            checks_failed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, " d_bright"}, 32'(d_bright), 0);
        check_output({tag, " d_x"}, 32'(d_x), 0);
        check_output({tag, " d_y"}, 32'(d_y), 0);
        check_output({tag, " d_h_sync"}, 32'(d_h_sync), 1);
        check_output({tag, " d_v_sync"}, 32'(d_v_sync), 1);
        check_output({tag, " d_line_start"}, 32'(d_line_start), 0);
        check_output({tag, " d_frame_start"}, 32'(d_frame_start), 0);
        check_output({tag, " s_bright"}, 32'(s_bright), 0);
        check_output({tag, " s_h_sync"}, 32'(s_h_sync), 1);
        check_output({tag, " s_v_sync"}, 32'(s_v_sync), 1);
        check_output({tag, " s_frame_start"}, 32'(s_frame_start), 0);
    endtask

    task automatic check_first_edge(input string tag);
        check_output({tag, " d_bright"}, 32'(d_bright), 1);
        check_output({tag, " d_x"}, 32'(d_x), 0);
        check_output({tag, " d_y"}, 32'(d_y), 0);
        check_output({tag, " d_line_start"}, 32'(d_line_start), 1);
        check_output({tag, " d_frame_start"}, 32'(d_frame_start), 1);
        check_output({tag, " d_h_sync"}, 32'(d_h_sync), 1);
        check_output({tag, " d_v_sync"}, 32'(d_v_sync), 1);
        check_output({tag, " s_bright"}, 32'(s_bright), 1);
        check_output({tag, " s_frame_start"}, 32'(s_frame_start), 1);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        repeat (3) tick();
        check_reset_values("reset");

        reset = 1'b0;
        tick();
        check_first_edge("first_edge");

        d_bright_ones = 0; d_first_dark = -1; d_hs_low = 0; d_hs_first = -1;
        d_ls_count = 0; d_fs_count = 0; d_vs_low = 0; d_pix_bad = 0;
        s_ls_count = 0; s_fs_count = 0; s_vs_low = 0; s_vs_first = -1; s_hs_low_line0 = 0;
        s_run = 0; s_runs = 0; s_glitch = 0; s_ones = 0; s_pix_bad = 0;

        // Index i is the raster position shown by the outputs, counted from the first edge.
        for (int i = 0; i < 1700; i++) begin
            if (i < 800) begin
                if (d_bright) d_bright_ones++;
                else if (d_first_dark < 0) d_first_dark = i;
                if (!d_h_sync) begin
                    d_hs_low++;
                    if (d_hs_first < 0) d_hs_first = i;
                end
            end
            if (i < 1600 && d_line_start) d_ls_count++;
            if (d_frame_start) d_fs_count++;
            if (!d_v_sync) d_vs_low++;
            if (!d_bright && (d_x != 10'd0 || d_y != 10'd0)) d_pix_bad++;
            if (i == 639) check_output("last_visible_x", 32'(d_x), 639);
            if (i == 800) begin
                check_output("line2_start", 32'(d_line_start), 1);
                check_output("line2_y", 32'(d_y), 1);
                check_output("line2_x", 32'(d_x), 0);
            end
            if (i == 1600) check_output("line3_y", 32'(d_y), 2);

            if (i < 176) begin
                if (s_line_start) s_ls_count++;
                if (s_frame_start) s_fs_count++;
                if (!s_v_sync) begin
                    s_vs_low++;
                    if (s_vs_first < 0) s_vs_first = i;
                end
            end
            if (i < 16 && !s_h_sync) s_hs_low_line0++;
            if (i == 175) check_output("small_last_bright", 32'(s_bright), 0);
            if (i == 176) begin
                check_output("small_wrap_fs", 32'(s_frame_start), 1);
                check_output("small_wrap_x", 32'(s_x), 0);
                check_output("small_wrap_y", 32'(s_y), 0);
            end
            if (i < 352) begin
                if (!s_bright && (s_x != 10'd0 || s_y != 10'd0)) s_pix_bad++;
                if (s_bright) begin
                    s_run++;
                    s_ones++;
                end else begin
                    if (s_run != 0 && s_run != 8) s_glitch++;
                    if (s_run != 0) s_runs++;
                    s_run = 0;
                end
            end
            tick();
        end

        check_output("line_bright_ones", 32'(d_bright_ones), 640);
        check_output("line_first_dark", 32'(d_first_dark), 640);
        check_output("line_hsync_low", 32'(d_hs_low), 96);
        check_output("line_hsync_first", 32'(d_hs_first), 656);
        check_output("line_start_count", 32'(d_ls_count), 2);
        check_output("frame_start_count", 32'(d_fs_count), 1);
        check_output("vsync_low_early", 32'(d_vs_low), 0);
        check_output("pixel_zero_blank", 32'(d_pix_bad), 0);
        check_output("small_line_starts", 32'(s_ls_count), 6);
        check_output("small_frame_starts", 32'(s_fs_count), 1);
        check_output("small_vsync_low", 32'(s_vs_low), 32);
        check_output("small_vsync_first", 32'(s_vs_first), 112);
        check_output("small_hsync_line0", 32'(s_hs_low_line0), 3);
        check_output("small_bright_runs", 32'(s_runs), 12);
        check_output("small_bright_ones", 32'(s_ones), 96);
        check_output("small_bright_glitch", 32'(s_glitch), 0);
        check_output("small_pixel_zero", 32'(s_pix_bad), 0);

        // Freeze mid-line at x=100 on line 2.
        check_output("pre_freeze_x", 32'(d_x), 100);
        check_output("pre_freeze_y", 32'(d_y), 2);
        enable = 1'b0;
        d_freeze_bad = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (d_x != 10'd100 || d_y != 10'd2 || !d_bright || d_line_start
                || d_frame_start || !d_h_sync || !d_v_sync) d_freeze_bad++;
        end
        check_output("freeze_hold", 32'(d_freeze_bad), 0);
        enable = 1'b1;
        tick();
        check_output("resume_x101", 32'(d_x), 101);
        tick();
        check_output("resume_x102", 32'(d_x), 102);

        // Freeze exactly on a line_start pulse: the pulse must not repeat.
        repeat (698) tick();
        check_output("line3_start", 32'(d_line_start), 1);
        check_output("line3_y", 32'(d_y), 3);
        enable = 1'b0;
        tick();
        check_output("frozen_pulse_drop", 32'(d_line_start), 0);
        check_output("frozen_x", 32'(d_x), 0);
        check_output("frozen_bright", 32'(d_bright), 1);
        enable = 1'b1;
        tick();
        check_output("after_pulse_x", 32'(d_x), 1);
        check_output("after_pulse_ls", 32'(d_line_start), 0);

        // Reset in the middle of active video.
        repeat (299) tick();
        check_output("pre_reset_x", 32'(d_x), 300);
        check_output("pre_reset_y", 32'(d_y), 3);
        reset = 1'b1;
        tick();
        check_reset_values("mid_reset");
        reset = 1'b0;
        tick();
        check_first_edge("restart");
        tick();
        check_output("restart_x1", 32'(d_x), 1);
        check_output("restart_fs_drop", 32'(d_frame_start), 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
